// File: rtl/input_realignment_window_pkg.sv
// Shared types and constants for the input realignment window.
//
// The activation word is N_DIM_ARRAY signed lanes of ACT_DATA_WIDTH bits each.
// Lane 0 sits in the least significant bits. OFFSET_W is wide enough to hold
// any lane index. zeroTail clears the lanes at and above a given lane count.
// A lane count of 0 means the whole word is valid.
package input_realignment_window_pkg;

    localparam int N_DIM_ARRAY    = 8;
    localparam int ACT_DATA_WIDTH = 8;
    localparam int CNT_W          = 16;
    localparam int OFFSET_W       = $clog2(N_DIM_ARRAY);
    localparam int WORD_W         = N_DIM_ARRAY * ACT_DATA_WIDTH;

    typedef logic signed [ACT_DATA_WIDTH-1:0] act_t;
    typedef act_t [N_DIM_ARRAY-1:0] act_word_t;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        STREAM,
        DRAIN,
        DONE
    } realign_state_t;

    // Mirrors the writer's right padding: lanes at and above 'lanes' read as zero.
    function automatic act_word_t zeroTail(input act_word_t w, input logic [OFFSET_W-1:0] lanes);
        act_word_t r;
        r = w;
        for (int i = 0; i < N_DIM_ARRAY; i++) begin
            if (lanes != '0 && i >= int'(lanes)) begin
                r[i] = '0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/input_realignment_window_shifter.sv
// realign_lane_shifter: combinational lane extractor.
//
// Ports:
//   held_i     - previously accepted word; forms lanes 0..N-1 of the combined vector
//   in_word_i  - current input word; forms lanes N..2N-1 of the combined vector
//   offset_i   - first useful lane
//   shifted_o  - combined[offset_i + i] for each lane i, or in_word_i when offset_i is 0
module realign_lane_shifter
    import input_realignment_window_pkg::*;
(
    input  act_word_t                held_i,
    input  act_word_t                in_word_i,
    input  logic [OFFSET_W-1:0]      offset_i,
    output act_word_t                shifted_o
);

    logic [2*WORD_W-1:0] combined;

    // Zero offset never primes a held word, so the current word passes straight
    // through. Otherwise, shift the two-word window down by whole lanes.
    always_comb begin
        combined = {in_word_i, held_i};
        if (offset_i == '0) begin
            shifted_o = in_word_i;
        end else begin
            shifted_o = WORD_W'(combined >> (int'(offset_i) * ACT_DATA_WIDTH));
        end
    end

endmodule

// File: rtl/input_realignment_window.sv
// input_realignment_window: re-extracts a contiguous activation stream that
// starts at a lane offset inside word-aligned memory words.
//
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   start                   - one-cycle pulse; latches offset/num_out_words/last_lanes when idle
//   offset                  - first valid lane in the first input word
//   num_out_words           - number of realigned words to produce
//   last_lanes              - valid lanes in the final output word (0 = all)
//   in_word/in_valid/in_ready     - memory-side valid/ready input
//   out_word/out_valid/out_ready  - array-side valid/ready output (registered)
//   busy                    - high whenever not IDLE
//   done                    - one-cycle pulse after the final output is accepted
//
// Optional build macro INPUT_REALIGN_TAIL_ZERO_EN: zeroes lanes >= last_lanes
// in the final output word. Without it, last_lanes is ignored.
module input_realignment_window
    import input_realignment_window_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [OFFSET_W-1:0]  offset,
    input  logic [CNT_W-1:0]     num_out_words,
    input  logic [OFFSET_W-1:0]  last_lanes,
    input  act_word_t            in_word,
    input  logic                 in_valid,
    output logic                 in_ready,
    output act_word_t            out_word,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done
);

    realign_state_t       state_q;
    logic [OFFSET_W-1:0]  offset_q;
    logic [CNT_W-1:0]     numOut_q;
    logic [CNT_W-1:0]     outCnt_q;
    logic [CNT_W-1:0]     outCnt_d;
    act_word_t            held_q;
    act_word_t            outWord_q;
    act_word_t            outWord_d;
    act_word_t            shifted;
    logic                 outValid_q;
    logic                 done_q;
    logic                 lastLoad;
    logic                 inFire;
    logic                 outFire;

`ifdef INPUT_REALIGN_TAIL_ZERO_EN
    logic [OFFSET_W-1:0]  lastLanes_q;
`else
    logic                 unusedLastLanes;
    assign unusedLastLanes = ^last_lanes;
`endif

    realign_lane_shifter u_shifter (
        .held_i    (held_q),
        .in_word_i (in_word),
        .offset_i  (offset_q),
        .shifted_o (shifted)
    );

    // Next output word and count, and the input-side ready decode. In STREAM,
    // input is taken only when the output register is free or emptying this
    // cycle, so a stalled output word is never overwritten.
    always_comb begin
        outCnt_d  = outCnt_q + CNT_W'(1);
        lastLoad  = (outCnt_d == numOut_q);
        outWord_d = shifted;
`ifdef INPUT_REALIGN_TAIL_ZERO_EN
        if (lastLoad) begin
            outWord_d = zeroTail(shifted, lastLanes_q);
        end
`endif
        case (state_q)
            PRIME:   in_ready = 1'b1;
            STREAM:  in_ready = !outValid_q || out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign inFire    = in_valid && in_ready;
    assign outFire   = outValid_q && out_ready;
    assign out_word  = outWord_q;
    assign out_valid = outValid_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    // Control FSM plus datapath registers. An accepted output clears out_valid
    // unless a new word loads in the same cycle, which keeps the stream bubble-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            offset_q    <= '0;
            numOut_q    <= '0;
            outCnt_q    <= '0;
            held_q      <= '0;
            outWord_q   <= '0;
            outValid_q  <= 1'b0;
            done_q      <= 1'b0;
`ifdef INPUT_REALIGN_TAIL_ZERO_EN
            lastLanes_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (outFire) begin
                outValid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        offset_q <= offset;
                        numOut_q <= num_out_words;
                        outCnt_q <= '0;
`ifdef INPUT_REALIGN_TAIL_ZERO_EN
                        lastLanes_q <= last_lanes;
`endif
                        if (num_out_words == '0) begin
                            state_q <= DONE;
                        end else if (offset == '0) begin
                            state_q <= STREAM;
                        end else begin
                            state_q <= PRIME;
                        end
                    end
                end
                PRIME: begin
                    if (inFire) begin
                        held_q  <= in_word;
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (inFire) begin
                        outWord_q  <= outWord_d;
                        held_q     <= in_word;
                        outValid_q <= 1'b1;
                        outCnt_q   <= outCnt_d;
                        if (lastLoad) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (outFire) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
